// File: rtl/game_pkg.sv
// Shared playfield constants and the line-clear engine state encoding.
// The grid store and the line-clear engine both import this package.
package game_pkg;

  localparam int ROWS = 20;  // playfield rows, row 0 is the top
  localparam int COLS = 10;  // playfield columns
  localparam int XW   = 4;   // column address width
  localparam int YW   = 5;   // row address width

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOAD,
    STORE,
    CLEAR_TOP,
    DONE
  } lce_state_t;

endpackage

// File: rtl/line_clear_engine.sv
// Line-clear engine: scans the playfield bottom-up and removes every full row.
// A removed row is replaced by shifting each row above it down by one,
// staging each row in a COLS-bit buffer, and then zero-filling row 0.
// The shifted-in row is rescanned at the same y before the scan moves up.
module line_clear_engine
  import game_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] lines_cleared,
  output logic [XW-1:0] cell_x,
  output logic [YW-1:0] cell_y,
  output logic          cell_rd_en,
  output logic          cell_wr_en,
  output logic          cell_wr_data,
  input  logic          cell_rd_data
);

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_BOT  = YW'(ROWS - 1);
  localparam logic [CW-1:0] LC_MAX = '1;

  lce_state_t      state, state_nxt;
  logic [XW-1:0]   x, x_nxt;          // column walker shared by all phases
  logic [YW-1:0]   y, y_nxt;          // scan row pointer
  logic [YW-1:0]   r, r_nxt;          // destination row of the current shift step
  logic [CW-1:0]   lc, lc_nxt;        // full rows removed in this pass
  logic [COLS-1:0] row_buf, row_buf_nxt;

  logic            x_end;
  logic [YW-1:0]   r_above;           // source row of the shift; never used while r == 0

  assign x_end         = (x == X_LAST);
  assign r_above       = r - YW'(1);
  assign lines_cleared = lc;

  // Next-state, counter/buffer updates and all grid port drives.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    state_nxt    = state;
    x_nxt        = x;
    y_nxt        = y;
    r_nxt        = r;
    lc_nxt       = lc;
    row_buf_nxt  = row_buf;
    busy         = (state != IDLE);
    done         = 1'b0;
    cell_rd_en   = 1'b0;
    cell_wr_en   = 1'b0;
    cell_wr_data = 1'b0;
    cell_x       = x;
    cell_y       = y;

    case (state)
      IDLE: begin
        if (start) begin
          lc_nxt    = '0;
          y_nxt     = Y_BOT;
          x_nxt     = '0;
          state_nxt = SCAN;
        end
      end

      SCAN: begin
        cell_rd_en = 1'b1;
        if (!cell_rd_data) begin
          // Row has a hole: move up, or finish after the top row.
          if (y == '0) begin
            state_nxt = DONE;
          end else begin
            y_nxt = y - YW'(1);
            x_nxt = '0;
          end
        end else if (!x_end) begin
          x_nxt = x + XW'(1);
        end else begin
          if (lc != LC_MAX) lc_nxt = lc + CW'(1);
          r_nxt     = y;
          x_nxt     = '0;
          state_nxt = (y == '0) ? CLEAR_TOP : LOAD;
        end
      end

      LOAD: begin
        cell_rd_en     = 1'b1;
        cell_y         = r_above;
        row_buf_nxt[x] = cell_rd_data;
        if (x_end) begin
          x_nxt     = '0;
          state_nxt = STORE;
        end else begin
          x_nxt = x + XW'(1);
        end
      end

      STORE: begin
        cell_wr_en   = 1'b1;
        cell_y       = r;
        cell_wr_data = row_buf[x];
        if (x_end) begin
          x_nxt     = '0;
          r_nxt     = r_above;
          state_nxt = (r_above == '0) ? CLEAR_TOP : LOAD;
        end else begin
          x_nxt = x + XW'(1);
        end
      end

      CLEAR_TOP: begin
        cell_wr_en = 1'b1;
        cell_y     = '0;
        if (x_end) begin
          x_nxt     = '0;
          state_nxt = SCAN;
        end else begin
          x_nxt = x + XW'(1);
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, pointers, counter and row buffer registers; reset aborts any pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      r       <= '0;
      lc      <= '0;
      // NOTE: the row buffer is a small flop register, so it is reset with everything else rather than left undefined like a RAM.
      row_buf <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      r       <= r_nxt;
      lc      <= lc_nxt;
      row_buf <= row_buf_nxt;
    end
  end

endmodule
